// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper board logic.
//   - FSM state encoding for reveal_ctrl
//   - action codes used on act_type
//   - default grid size
package minesweeper_pkg;

    localparam int GRID_SIZE_DEFAULT = 8;

    localparam logic ACT_REVEAL = 1'b0;
    localparam logic ACT_FLAG   = 1'b1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_MERGE = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_OVER  = 3'd5;
    localparam logic [2:0] ST_DRAIN = 3'd6;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        WAIT  = ST_WAIT,
        MERGE = ST_MERGE,
        CHECK = ST_CHECK,
        OVER  = ST_OVER,
        DRAIN = ST_DRAIN
    } state_t;

endpackage

// File: rtl/reveal_watchdog.sv
// Flood-fill watchdog: a down-counter that reloads whenever it is cleared or
// disabled and flags expiry once it has been enabled for LIMIT cycles.
// Ports:
//   clk, rst (async, active-low)
//   clear   - reload the counter
//   enable  - count this cycle
//   expire  - high in the LIMIT-th consecutive enabled cycle
module reveal_watchdog #(
    parameter int WIDTH = 16,
    parameter int LIMIT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WIDTH-1:0] LOAD = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= LOAD;
        end else if (clear || !enable) begin
            cnt_q <= LOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - ONE;
        end
    end

    // Terminal count: zero is reached in the LIMIT-th enabled cycle.
    assign expire = enable && !clear && (cnt_q == '0);

endmodule

// File: rtl/reveal_ctrl.sv
// Board-state controller between the player-input decoder and flood_fill.
// Owns the revealed/flagged registers, launches flood_fill for safe reveals,
// merges its result and reports loss or win.
// Optional feature: define REVEAL_TIMEOUT_EN to build a watchdog on the flood
// handshake (timeout_err); otherwise timeout_err is tied low.
// Ports:
//   clk, rst (async, active-low), new_game (clear pulse), mines (mine map)
//   act_valid/act_ready/act_type/act_index  - action handshake
//   ff_start/ff_root_index                  - flood launch
//   ff_result_mask/ff_done                  - flood result
//   revealed, flagged, flag_count           - board state
//   game_over, game_won, timeout_err        - sticky status
//
// state | meaning
// IDLE  | ready for an action
// START | ff_start pulse for the captured root
// WAIT  | waiting for ff_done
// MERGE | result merged; win check decides OVER or IDLE
// CHECK | win check (same decision as MERGE)
// OVER  | game lost or won, actions refused
// DRAIN | new_game during a flood; swallow the stale ff_done
module reveal_ctrl
    import minesweeper_pkg::*;
#(
    parameter int GRID_SIZE      = GRID_SIZE_DEFAULT,
    parameter int TOTAL_TILES    = GRID_SIZE * GRID_SIZE,
    parameter int INDEX_BITS     = $clog2(TOTAL_TILES),
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   new_game,
    input  logic [TOTAL_TILES-1:0] mines,
    input  logic                   act_valid,
    output logic                   act_ready,
    input  logic                   act_type,
    input  logic [INDEX_BITS-1:0]  act_index,
    output logic                   ff_start,
    output logic [INDEX_BITS-1:0]  ff_root_index,
    input  logic [TOTAL_TILES-1:0] ff_result_mask,
    input  logic                   ff_done,
    output logic [TOTAL_TILES-1:0] revealed,
    output logic [TOTAL_TILES-1:0] flagged,
    output logic [INDEX_BITS:0]    flag_count,
    output logic                   game_over,
    output logic                   game_won,
    output logic                   timeout_err
);

    localparam logic [INDEX_BITS:0] CNT_ONE = (INDEX_BITS + 1)'(1);

    state_t                 state_q, state_d;
    logic [TOTAL_TILES-1:0] revealed_q, revealed_d;
    logic [TOTAL_TILES-1:0] flagged_q, flagged_d;
    logic [INDEX_BITS:0]    flag_count_q, flag_count_d;
    logic [INDEX_BITS-1:0]  idx_q, idx_d;
    logic                   game_over_q, game_over_d;
    logic                   game_won_q, game_won_d;

`ifdef REVEAL_TIMEOUT_EN
    logic timeout_q, timeout_d;
    logic wd_expire;

    reveal_watchdog #(
        .WIDTH (16),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (new_game),
        .enable ((state_q == WAIT) || (state_q == DRAIN)),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) timeout_q <= 1'b0;
        else      timeout_q <= timeout_d;
    end

    assign timeout_err = timeout_q;
`else
    // No watchdog in this build: the limit is irrelevant and the flag stays low.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            revealed_q   <= '0;
            flagged_q    <= '0;
            flag_count_q <= '0;
            idx_q        <= '0;
            game_over_q  <= 1'b0;
            game_won_q   <= 1'b0;
        end else begin
            revealed_q   <= revealed_d;
            flagged_q    <= flagged_d;
            flag_count_q <= flag_count_d;
            idx_q        <= idx_d;
            game_over_q  <= game_over_d;
            game_won_q   <= game_won_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        revealed_d   = revealed_q;
        flagged_d    = flagged_q;
        flag_count_d = flag_count_q;
        idx_d        = idx_q;
        game_over_d  = game_over_q;
        game_won_d   = game_won_q;
`ifdef REVEAL_TIMEOUT_EN
        timeout_d    = timeout_q;
`endif

        if (new_game) begin
            revealed_d   = '0;
            flagged_d    = '0;
            flag_count_d = '0;
            game_over_d  = 1'b0;
            game_won_d   = 1'b0;
`ifdef REVEAL_TIMEOUT_EN
            timeout_d    = 1'b0;
`endif
            // A flood already launched will still answer; swallow it in DRAIN.
            if (state_q == START || state_q == WAIT) state_d = DRAIN;
            else                                     state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (act_valid) begin
                        if (act_type == ACT_FLAG) begin
                            if (!revealed_q[act_index]) begin
                                flagged_d[act_index] = ~flagged_q[act_index];
                                flag_count_d = flagged_q[act_index] ? flag_count_q - CNT_ONE
                                                                    : flag_count_q + CNT_ONE;
                            end
                        end else if (!revealed_q[act_index] && !flagged_q[act_index]) begin
                            if (mines[act_index]) begin
                                revealed_d  = revealed_q | mines;
                                game_over_d = 1'b1;
                                state_d     = OVER;
                            end else begin
                                idx_d   = act_index;
                                state_d = START;
                            end
                        end
                    end
                end
                START: state_d = WAIT;
                WAIT: begin
                    if (ff_done) begin
                        // Flagged tiles stay hidden even if the flood covers them.
                        revealed_d = revealed_q | (ff_result_mask & ~flagged_q);
                        state_d    = MERGE;
                    end
`ifdef REVEAL_TIMEOUT_EN
                    else if (wd_expire) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
`endif
                end
                // The win check is taken on MERGE's exit so act_ready/game_won
                // appear two cycles after ff_done; CHECK shares the decision.
                MERGE, CHECK: begin
                    if (&(revealed_q | mines)) begin
                        game_won_d = 1'b1;
                        state_d    = OVER;
                    end else begin
                        state_d = IDLE;
                    end
                end
                OVER: state_d = OVER;
                DRAIN: begin
                    if (ff_done) state_d = IDLE;
`ifdef REVEAL_TIMEOUT_EN
                    else if (wd_expire) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign act_ready     = (state_q == IDLE);
    assign ff_start      = (state_q == START);
    assign ff_root_index = idx_q;
    assign revealed      = revealed_q;
    assign flagged       = flagged_q;
    assign flag_count    = flag_count_q;
    assign game_over     = game_over_q;
    assign game_won      = game_won_q;

endmodule
